// File: rtl/ysyx_pkg.sv
// Shared types and constants for the ysyx instruction fetch unit.
package ysyx_pkg;

    localparam int unsigned XLEN          = 32;
    localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h8000_0000;
    localparam int unsigned IFU_DEPTH     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ifu_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ysyx_ifu_if.sv
// Fetch-side bus bundle: imem request/response, IDU instruction port, EXU redirect.
interface ysyx_ifu_if;
    import ysyx_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    logic            jump;
    logic [XLEN-1:0] jump_addr;

    modport ifu (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready, jump, jump_addr
    );

    modport env (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready, jump, jump_addr
    );

endinterface

// File: rtl/ysyx_fifo.sv
// Synchronous FIFO with flush; extra pointer bit distinguishes full from empty.
module ysyx_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_count == PW'(DEPTH));
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_count = w_count;

endmodule

// File: rtl/ysyx_ifu.sv
// Decoupled instruction fetch: one outstanding imem request, {pc, inst} queue to IDU,
// jump redirect flushes the queue and drops any stale in-flight response.
module ysyx_ifu import ysyx_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DFLT,
    parameter int unsigned     DEPTH    = IFU_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    ysyx_ifu_if.ifu    bus
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    ifu_state_t      r_state;
    ifu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_req_valid;

    logic            w_req_fire;
    logic            w_resp;
    logic            w_pop;
    logic            w_push;
    logic            w_empty;
    logic [PW-1:0]   w_count;
    logic [PW-1:0]   w_count_after;
    ifu_entry_t      w_wentry;
    ifu_entry_t      w_head;

    assign w_req_fire    = r_req_valid & bus.imem_req_ready;
    // Responses with nothing outstanding (e.g. across a reset) are ignored.
    assign w_resp        = bus.imem_resp_valid & r_inflight;
    assign w_pop         = ~w_empty & bus.inst_ready;
    assign w_count_after = w_count + PW'(1) - PW'(w_pop);
    assign w_wentry      = {r_req_pc, bus.imem_resp_data};

    ysyx_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.jump),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (bus.inst_ready),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state, next fetch PC and queue push; jump overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.jump || (w_count < PW'(DEPTH))) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt    = bus.jump ? S_DROP : S_WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
                end
            end
            S_WAIT: begin
                if (w_resp) begin
                    if (bus.jump) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = (w_count_after < PW'(DEPTH)) ? S_REQ : S_IDLE;
                    end
                end else if (bus.jump) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (w_resp) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
        if (bus.jump) w_fetch_pc_nxt = word_align(bus.jump_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_inflight  <= 1'b0;
            r_req_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_req_valid <= (w_state_nxt == S_REQ);
            if (w_req_fire) begin
                r_req_pc   <= r_fetch_pc;
                r_inflight <= 1'b1;
            end else if (w_resp) begin
                r_inflight <= 1'b0;
            end
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = ~w_empty;
    assign bus.inst           = w_head.inst;
    assign bus.inst_pc        = w_head.pc;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: memory/IDU models with a golden PC+4 stream checker.
module tb_ysyx_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    ysyx_ifu_if bus ();

    ysyx_ifu #(.RESET_PC(RST_PC), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Environment controls (written by the main sequence just after posedge)
    int          mem_pct = 0, dmin = 0, dmax = 0, idu_pct = 0;
    bit          idu_once = 0;
    int          jmp_mode = 0;   // 0 none, 1 asap, 2 with req handshake, 3 with resp, 4 in wait
    logic [31:0] jmp_tgt = '0;

    // Observations
    int          cyc = 0, hs_cnt = 0, resp_cnt = 0, pop_cnt = 0, jmp_cnt = 0;
    int          first_hs_cyc = -1, first_valid_cyc = -1;
    logic [31:0] hs_log[$];
    int          hs_cyc_log[$];
    logic [31:0] last_hs = '0, exp_pc = RST_PC, exp_next_hs = RST_PC, pj_pop_pc = '0;
    bit          exp_next_hs_valid = 0, pj_pending = 0, saw_wrap = 0, chk_empty = 0;
    int          chk_empty_cyc = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    // Memory, redirect and IDU models, all evaluated on the falling edge.
    initial begin
        logic v, rq_v, r_v, hs, j, ir, in_wait;
        logic [31:0] ip, id, rq_a;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
        bus.inst_ready = 0; bus.jump = 0; bus.jump_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            v = bus.inst_valid; ip = bus.inst_pc; id = bus.inst;
            rq_v = bus.imem_req_valid; rq_a = bus.imem_req_addr;
            if (chk_empty && cyc == chk_empty_cyc) begin
                chk("flush_empty", 32'(v), 32'd0);
                chk_empty = 0;
            end
            if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
            r_v = 0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    r_v = 1; pend = 0; resp_cnt++;
                end else pend_cnt--;
            end
            bus.imem_resp_valid = r_v;
            bus.imem_resp_data  = r_v ? memf(pend_addr) : 32'hDEAD_BEEF;
            in_wait = pend;
            bus.imem_req_ready = rst && ($urandom_range(99, 0) < 32'(mem_pct));
            hs = bus.imem_req_ready && rq_v;
            if (hs) begin
                chk("single_outstanding", 32'(pend), 32'd0);
                if (exp_next_hs_valid) begin
                    chk("req_addr_after_redirect", rq_a, exp_next_hs);
                    exp_next_hs_valid = 0;
                end
                if (rq_a == 32'h0 && last_hs == 32'hFFFF_FFFC) saw_wrap = 1;
                pend = 1; pend_cnt = int'($urandom_range(dmax, dmin)); pend_addr = rq_a;
                hs_log.push_back(rq_a); hs_cyc_log.push_back(cyc);
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                hs_cnt++; last_hs = rq_a;
            end
            case (jmp_mode)
                1: j = 1;
                2: j = hs;
                3: j = r_v;
                4: j = in_wait && !r_v;
                default: j = 0;
            endcase
            if (!rst) j = 0;
            bus.jump = j;
            bus.jump_addr = jmp_tgt;
            if (j) begin
                jmp_mode = 0; jmp_cnt++;
                exp_pc = jmp_tgt & ~32'd3;
                exp_next_hs = jmp_tgt & ~32'd3; exp_next_hs_valid = 1;
                chk_empty = 1; chk_empty_cyc = cyc + 1; pj_pending = 1;
            end
            ir = rst && (idu_once || ($urandom_range(99, 0) < 32'(idu_pct)));
            idu_once = 0;
            bus.inst_ready = ir;
            if (v && ir && !j && rst) begin
                chk("pop_pc", ip, exp_pc);
                chk("pop_inst", id, memf(ip));
                if (pj_pending) begin pj_pop_pc = ip; pj_pending = 0; end
                exp_pc = exp_pc + 32'd4;
                pop_cnt++;
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_obs();
        hs_cnt = 0; resp_cnt = 0; pop_cnt = 0;
        first_hs_cyc = -1; first_valid_cyc = -1;
        hs_log.delete(); hs_cyc_log.delete();
        exp_pc = RST_PC; exp_next_hs = RST_PC; exp_next_hs_valid = 1;
        pj_pending = 0; saw_wrap = 0; last_hs = '0; chk_empty = 0;
    endtask

    task automatic do_reset();
        mem_pct = 0; idu_pct = 0; jmp_mode = 0;
        step(8);
        rst = 0;
        step(2);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        clear_obs();
        rst = 1;
    endtask

    task automatic do_jump(input int mode, input logic [31:0] tgt);
        int c0;
        c0 = jmp_cnt; jmp_tgt = tgt; jmp_mode = mode;
        for (int k = 0; k < 60 && jmp_cnt == c0; k++) step(1);
        chk("jump_taken", 32'(jmp_cnt), 32'(c0 + 1));
        jmp_mode = 0;
    endtask

    task automatic drain_and_count();
        mem_pct = 0;
        step(10);
        chk("req_eq_resp", 32'(hs_cnt), 32'(resp_cnt));
    endtask

    typedef struct {
        int          mem_pct;
        int          dmin;
        int          dmax;
        int          idu_pct;
        logic [31:0] start;
        int          cycles;
        int          min_pops;
        bit          exp_wrap;
    } scen_t;

    scen_t scen[4];

    initial begin
        int c0;
        scen[0] = '{100, 0, 0, 100, 32'hFFFF_FFF0,  60, 20, 1'b1};
        scen[1] = '{ 50, 0, 5,  50, 32'hFFFF_FFE8, 400, 15, 1'b1};
        scen[2] = '{100, 5, 5, 100, 32'h8000_1000, 200, 15, 1'b0};
        scen[3] = '{ 30, 0, 1,  20, 32'h0000_0040, 300, 10, 1'b0};
        rst = 0;

        // Reset release, zero-wait memory: in-order addresses, 2-cycle latency, 1 inst / 2 cycles
        do_reset();
        mem_pct = 100; dmin = 0; dmax = 0; idu_pct = 100;
        step(14);
        chk("t1_hs0", hs_log.size() > 0 ? hs_log[0] : 32'hX, 32'h8000_0000);
        chk("t1_hs1", hs_log.size() > 1 ? hs_log[1] : 32'hX, 32'h8000_0004);
        chk("t1_hs2", hs_log.size() > 2 ? hs_log[2] : 32'hX, 32'h8000_0008);
        chk("t1_latency", 32'(first_valid_cyc - first_hs_cyc), 32'd2);
        chk("t1_spacing", hs_cyc_log.size() > 1 ? 32'(hs_cyc_log[1] - hs_cyc_log[0]) : 32'hX, 32'd2);
        drain_and_count();

        // Backpressure: queue fills to DEPTH, request stops, one pop restarts at +0x10
        do_reset();
        mem_pct = 100; dmin = 0; dmax = 0; idu_pct = 0;
        step(30);
        chk("t2_hs_full", 32'(hs_cnt), 32'd4);
        chk("t2_req_idle", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(bus.inst_valid), 32'd1);
        chk("t2_head_pc", bus.inst_pc, 32'h8000_0000);
        idu_once = 1;
        step(12);
        chk("t2_hs_after_pop", 32'(hs_cnt), 32'd5);
        chk("t2_next_addr", last_hs, 32'h8000_0010);
        chk("t2_pops", 32'(pop_cnt), 32'd1);
        drain_and_count();

        // Redirect while waiting for a response
        do_reset();
        mem_pct = 100; dmin = 3; dmax = 3; idu_pct = 100;
        step(6);
        do_jump(4, 32'h8000_0102);
        step(20);
        chk("t3_first_pc", pj_pop_pc, 32'h8000_0100);
        drain_and_count();

        // Redirect coinciding with a request handshake and with a response
        do_reset();
        mem_pct = 100; dmin = 0; dmax = 2; idu_pct = 70;
        for (int i = 0; i < 3; i++) begin
            do_jump(2, 32'h8000_2000 + 32'(i * 64));
            step(10);
            chk("t4_hs_jump_pc", pj_pop_pc, 32'h8000_2000 + 32'(i * 64));
            do_jump(3, 32'h8000_3001 + 32'(i * 64));
            step(10);
            chk("t4_resp_jump_pc", pj_pop_pc, 32'h8000_3000 + 32'(i * 64));
        end
        drain_and_count();

        // Table of randomized-timing scenarios, including address wrap
        for (int s = 0; s < 4; s++) begin
            do_reset();
            mem_pct = scen[s].mem_pct; dmin = scen[s].dmin; dmax = scen[s].dmax;
            idu_pct = scen[s].idu_pct;
            do_jump(1, scen[s].start);
            step(scen[s].cycles);
            chk("t5_min_pops", 32'(pop_cnt >= scen[s].min_pops), 32'd1);
            chk("t5_wrap", 32'(saw_wrap), 32'(scen[s].exp_wrap));
            drain_and_count();
        end

        // Reset during an outstanding request; late response must be ignored
        do_reset();
        mem_pct = 100; dmin = 4; dmax = 4; idu_pct = 100;
        do_jump(1, 32'h8000_0400);
        c0 = 0;
        for (int k = 0; k < 40 && !(pend && pend_addr == 32'h8000_0400); k++) step(1);
        chk("t6_req_out", pend_addr, 32'h8000_0400);
        mem_pct = 0;
        rst = 0;
        step(2);
        clear_obs();
        rst = 1;
        pj_pending = 1;
        step(6);
        chk("t6_late_resp_seen", 32'(resp_cnt), 32'd1);
        chk("t6_no_inst", 32'(bus.inst_valid), 32'd0);
        dmin = 0; dmax = 0; mem_pct = 100;
        step(20);
        chk("t6_first_pc", pj_pop_pc, RST_PC);
        chk("t6_popped", 32'(pop_cnt > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
